// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, default memory depth.
package mem_access_pkg;

  localparam int DM_DEPTH_DEFAULT = 64;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bus of the load/store unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads; the store lane merge exists only
// with MEM_ACCESS_UNIT_SUBWORD_EN defined.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
`endif
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_load_data = i_rdata;
    case (i_size)
      SIZE_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default:   o_load_data = i_rdata;
    endcase
  end

`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
  always_comb begin
    o_merged = i_rdata;
    case (i_size)
      SIZE_BYTE: o_merged[{i_addr_lo, 3'b000} +: 8]        = i_wdata[7:0];
      SIZE_HALF: o_merged[{i_addr_lo[1], 4'b0000} +: 16]   = i_wdata[15:0];
      default:   o_merged = i_wdata;
    endcase
  end
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a single-ported word data memory.
// Byte/half accesses (read-modify-write stores) only with MEM_ACCESS_UNIT_SUBWORD_EN.
//
// state   | meaning
// IDLE    | ready for a request
// RD      | Mem_Read strobe; word captured at the closing edge
// WR      | single Mem_Write strobe
// RESP    | rsp_valid pulse
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DM_DEPTH = DM_DEPTH_DEFAULT
)
(
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic [31:0]       Mem_ID,
  output logic              Mem_Write,
  output logic              Mem_Read,
  output logic [31:0]       Mem_WData,
  input  logic [31:0]       Mem_RData
);

  localparam logic [31:0] DM_DEPTH_W = 32'(DM_DEPTH);

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_mem_id;
  logic [31:0] r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_accept;
  logic        w_size_err;
  logic        w_range_err;
  logic        w_req_err;
  logic [31:0] w_load_data;
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
  logic [31:0] w_merged;
`endif

  assign w_accept = bus.req_valid && (r_state == ST_IDLE);

  always_comb begin
    w_size_err = 1'b1;
    case (bus.req_size)
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
      SIZE_BYTE: w_size_err = 1'b0;
      SIZE_HALF: w_size_err = bus.req_addr[0];
`endif
      SIZE_WORD: w_size_err = (bus.req_addr[1:0] != 2'b00);
      default:   w_size_err = 1'b1;
    endcase
  end

  assign w_range_err = ({2'b00, bus.req_addr[31:2]} >= DM_DEPTH_W);
  assign w_req_err   = w_size_err || w_range_err;

  // Mem_WData doubles as the registered store data until the merge replaces it.
  mem_lane_align u_lane_align (
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_addr_lo   (r_addr_lo),
    .i_rdata     (Mem_RData),
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
    .i_wdata     (r_mem_wdata),
    .o_merged    (w_merged),
`endif
    .o_load_data (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_size      <= SIZE_WORD;
      r_unsigned  <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_mem_id    <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write    <= bus.req_write;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_addr_lo  <= bus.req_addr[1:0];
            if (w_req_err) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_mem_id <= {2'b00, bus.req_addr[31:2]};
              if (bus.req_write) r_mem_wdata <= bus.req_wdata;
              if (bus.req_write && (bus.req_size == SIZE_WORD)) begin
                r_state     <= ST_WR;
                r_mem_write <= 1'b1;
              end else begin
                r_state    <= ST_RD;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        ST_RD: begin
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
          if (r_write) begin
            r_state     <= ST_WR;
            r_mem_write <= 1'b1;
            r_mem_wdata <= w_merged;
          end else
`endif
          begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_write ? 32'h0 : w_load_data;
          end
        end
        ST_WR: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign Mem_ID        = r_mem_id;
  assign Mem_Read      = r_mem_read;
  assign Mem_Write     = r_mem_write;
  assign Mem_WData     = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural 64-word data memory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int DEPTH = 64;
`ifdef MEM_ACCESS_UNIT_SUBWORD_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wword;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wword;
    logic [31:0] id;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Mem_ID, Mem_WData, Mem_RData;
  logic        Mem_Write, Mem_Read;
  logic [31:0] mem [DEPTH];
  logic [31:0] last_id;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.DM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .Mem_ID    (Mem_ID),
    .Mem_Write (Mem_Write),
    .Mem_Read  (Mem_Read),
    .Mem_WData (Mem_WData),
    .Mem_RData (Mem_RData)
  );

  assign Mem_RData = (Mem_ID < DEPTH) ? mem[Mem_ID[5:0]] : 32'h0;

  always @(posedge clk)
    if (Mem_Write && (Mem_ID < DEPTH)) mem[Mem_ID[5:0]] <= Mem_WData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_req(input int idx, input vec_t v);
    exp_t e;
    exp_t got_e;
    int   n;
    int   rd_n;
    int   wr_n;
    bit   got;
    bit   both;
    bit   range_bad;
    string tag;
    tag = $sformatf("v%0d", idx);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);

    e.err = v.err;
    e.rdata = v.rdata;
    e.wword = v.wword;
    if (v.err) begin
      e.id = last_id; e.lat = 1; e.rd = 0; e.wr = 0;
    end else begin
      e.id = {2'b00, v.addr[31:2]};
      last_id = e.id;
      if (v.wr && v.sz == SIZE_WORD) begin e.lat = 2; e.rd = 0; e.wr = 1; end
      else if (v.wr)                 begin e.lat = 3; e.rd = 1; e.wr = 1; end
      else                           begin e.lat = 2; e.rd = 1; e.wr = 0; end
    end

    bus.req_valid    = 1'b1;
    bus.req_write    = v.wr;
    bus.req_size     = v.sz;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    sb_q.push_back(e);
    @(posedge clk);

    rd_n = 0; wr_n = 0; got = 1'b0; both = 1'b0; range_bad = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      if (Mem_Read && Mem_Write) both = 1'b1;
      if (Mem_ID >= DEPTH) range_bad = 1'b1;
      if (Mem_Read) begin
        rd_n++;
        chk({tag, "_rd_id"}, Mem_ID, e.id);
      end
      if (Mem_Write) begin
        wr_n++;
        chk({tag, "_wr_id"}, Mem_ID, e.id);
        chk({tag, "_wr_data"}, Mem_WData, e.wword);
      end
      if (bus.rsp_valid) begin
        got = 1'b1;
        got_e = sb_q.pop_front();
        chk({tag, "_err"},     32'(bus.rsp_err), 32'(got_e.err));
        chk({tag, "_rdata"},   bus.rsp_rdata, got_e.rdata);
        chk({tag, "_latency"}, 32'(i + 1), 32'(got_e.lat));
        chk({tag, "_n_read"},  32'(rd_n), 32'(got_e.rd));
        chk({tag, "_n_write"}, 32'(wr_n), 32'(got_e.wr));
        chk({tag, "_mem_id"},  Mem_ID, got_e.id);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_rsp_timeout: got no rsp_valid, want one within 8 cycles", tag);
      void'(sb_q.pop_front());
    end
    chk({tag, "_rd_wr_excl"}, 32'(both), 32'd0);
    chk({tag, "_id_range"}, 32'(range_bad), 32'd0);

    @(negedge clk);
    chk({tag, "_pulse"},     32'(bus.rsp_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_err_hold"},  32'(bus.rsp_err), 32'(e.err));
    chk({tag, "_rdata_hold"}, bus.rsp_rdata, e.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    vec_t rv;
    // wr sz uns addr wdata | err rdata wword
    vecs.push_back('{1'b1, SIZE_WORD, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b1, SIZE_BYTE, 1'b0, 32'h09, 32'h55, !SW, 32'h0, 32'hDEAD55EF});
    vecs.push_back('{1'b0, SIZE_BYTE, 1'b0, 32'h0B, 32'h0, !SW, SW ? 32'hFFFFFFDE : 32'h0, 32'h0});
    vecs.push_back('{1'b0, SIZE_BYTE, 1'b1, 32'h0B, 32'h0, !SW, SW ? 32'h000000DE : 32'h0, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0, 1'b0, SW ? 32'hDEAD55EF : 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b0, SIZE_BYTE, 1'b0, 32'h08, 32'h0, !SW, SW ? 32'hFFFFFFEF : 32'h0, 32'h0});
    vecs.push_back('{1'b0, SIZE_BYTE, 1'b1, 32'h09, 32'h0, !SW, SW ? 32'h00000055 : 32'h0, 32'h0});
    vecs.push_back('{1'b0, SIZE_HALF, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 32'h0});
    vecs.push_back('{1'b1, SIZE_WORD, 1'b0, 32'h0C, 32'h12345678, 1'b0, 32'h0, 32'h12345678});
    vecs.push_back('{1'b1, SIZE_HALF, 1'b0, 32'h0E, 32'hFFFFA5A5, !SW, 32'h0, 32'hA5A55678});
    vecs.push_back('{1'b0, SIZE_HALF, 1'b0, 32'h0E, 32'h0, !SW, SW ? 32'hFFFFA5A5 : 32'h0, 32'h0});
    vecs.push_back('{1'b0, SIZE_HALF, 1'b1, 32'h0C, 32'h0, !SW, SW ? 32'h00005678 : 32'h0, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 1'b0, 32'h0C, 32'h0, 1'b0, SW ? 32'hA5A55678 : 32'h12345678, 32'h0});
    vecs.push_back('{1'b0, 2'b11,     1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 32'h0});
    vecs.push_back('{1'b1, SIZE_WORD, 1'b0, 32'hFC, 32'hCAFEF00D, 1'b0, 32'h0, 32'hCAFEF00D});
    vecs.push_back('{1'b0, SIZE_WORD, 1'b0, 32'hFC, 32'h0, 1'b0, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{1'b1, SIZE_WORD, 1'b0, 32'h0A, 32'h11111111, 1'b1, 32'h0, 32'h0});
    vecs.push_back('{1'b0, SIZE_WORD, 1'b0, 32'h80000008, 32'h0, 1'b1, 32'h0, 32'h0});

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    last_id          = 32'h0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = SIZE_WORD;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",     32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_mem_id",    Mem_ID, 32'h0);
    chk("rst_mem_wdata", Mem_WData, 32'h0);
    chk("rst_mem_read",  32'(Mem_Read), 32'd0);
    chk("rst_mem_write", 32'(Mem_Write), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_req(i, vecs[i]);

    // Reset while a load sits in RD: the load must vanish without a response.
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = SIZE_WORD;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0C;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort_in_rd", 32'(Mem_Read), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    pulses = bus.rsp_valid ? 1 : 0;
    chk("abort_mem_read", 32'(Mem_Read), 32'd0);
    chk("abort_mem_id",   Mem_ID, 32'h0);
    chk("abort_rsp_err",  32'(bus.rsp_err), 32'd0);
    chk("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
    rst_n = 1'b1;
    last_id = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
      if (i == 0) chk("abort_ready_after_rst", 32'(bus.req_ready), 32'd1);
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    rv = vecs[5];
    run_req(100, rv);

    chk("mem_word2",  mem[2],  SW ? 32'hDEAD55EF : 32'hDEADBEEF);
    chk("mem_word3",  mem[3],  SW ? 32'hA5A55678 : 32'h12345678);
    chk("mem_word63", mem[63], 32'hCAFEF00D);
    chk("mem_word4",  mem[4],  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
